// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard inputs from the pipeline stages and the latch/PC controls back to them.
// Carries stallcnt/flushcnt when HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REGW = 5
);
  logic            ihit;
  logic            dhit;
  logic            memdREN;
  logic            memdWEN;
  logic            exdREN;
  logic [REGW-1:0] exwsel;
  logic [REGW-1:0] idrs;
  logic [REGW-1:0] idrt;
  logic            idrtUsed;
  logic            exPCSrc;
  logic            wbcuHALT;
  logic            pcW;
  logic            ifidW;
  logic            ifidRST;
  logic            idexW;
  logic            idexRST;
  logic            exmemW;
  logic            exmemRST;
  logic            memW;
  logic            memRST;
  logic            halt;
  logic            dtimeout;
`ifdef HAZARD_PERF_EN
  logic [31:0]     stallcnt;
  logic [31:0]     flushcnt;
`endif

  modport master (
    output ihit, dhit, memdREN, memdWEN, exdREN, exwsel, idrs, idrt, idrtUsed, exPCSrc,
           wbcuHALT,
`ifdef HAZARD_PERF_EN
    input  stallcnt, flushcnt,
`endif
    input  pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST, memW, memRST, halt,
           dtimeout
  );

  modport slave (
    input  ihit, dhit, memdREN, memdWEN, exdREN, exwsel, idrs, idrt, idrtUsed, exPCSrc,
           wbcuHALT,
`ifdef HAZARD_PERF_EN
    output stallcnt, flushcnt,
`endif
    output pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST, memW, memRST, halt,
           dtimeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: dmem waits, load-use, branches, halt.
// Optional HAZARD_PERF_EN adds free-running stall and flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned DWAIT_MAX = 0,
  parameter int unsigned REGW      = 5
) (
  input logic               CLK,
  input logic               nRST,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned CntW = (DWAIT_MAX > 0) ? $clog2(DWAIT_MAX + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DWAIT_MAX);

  typedef enum logic [1:0] {StRun, StDwait, StHalted} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wcnt_q, wcnt_d;
  logic            dto_q, dto_d;

  logic [REGW-1:0] exwsel, idrs, idrt;
  logic            dreq, dstall, load_use, flush_rule;
  logic            pc_w, ifid_w, ifid_rst, idex_w, idex_rst, exmem_w, exmem_rst, mem_w, mem_rst;

  assign exwsel   = bus.exwsel;
  assign idrs     = bus.idrs;
  assign idrt     = bus.idrt;
  assign dreq     = bus.memdREN | bus.memdWEN;
  assign dstall   = dreq & ~bus.dhit;
  assign load_use = bus.exdREN & (exwsel != '0) &
                    ((exwsel == idrs) | (bus.idrtUsed & (exwsel == idrt)));

  always_comb begin
    pc_w       = 1'b1;
    ifid_w     = 1'b1;
    ifid_rst   = 1'b0;
    idex_w     = 1'b1;
    idex_rst   = 1'b0;
    exmem_w    = 1'b1;
    exmem_rst  = 1'b0;
    mem_w      = 1'b1;
    mem_rst    = 1'b0;
    flush_rule = 1'b0;
    if (state_q == StHalted) begin
      {pc_w, ifid_w, idex_w, exmem_w, mem_w} = '0;
    end else if (bus.wbcuHALT || dstall) begin
      {pc_w, ifid_w, idex_w, exmem_w} = '0;
      mem_rst = 1'b1;
    end else begin
      if (bus.exPCSrc) begin
        flush_rule = 1'b1;
        ifid_rst   = 1'b1;
        idex_rst   = 1'b1;
      end else if (load_use) begin
        pc_w     = 1'b0;
        ifid_w   = 1'b0;
        idex_rst = 1'b1;
      end
      // A taken branch must still redirect the PC even while the fetch misses.
      if (!bus.ihit) begin
        if (!bus.exPCSrc) pc_w = 1'b0;
        if (ifid_w) ifid_rst = 1'b1;
      end
    end
    ifid_w  = ifid_w & ~ifid_rst;
    idex_w  = idex_w & ~idex_rst;
    exmem_w = exmem_w & ~exmem_rst;
    mem_w   = mem_w & ~mem_rst;
  end

  assign bus.pcW      = pc_w;
  assign bus.ifidW    = ifid_w;
  assign bus.ifidRST  = ifid_rst;
  assign bus.idexW    = idex_w;
  assign bus.idexRST  = idex_rst;
  assign bus.exmemW   = exmem_w;
  assign bus.exmemRST = exmem_rst;
  assign bus.memW     = mem_w;
  assign bus.memRST   = mem_rst;
  assign bus.halt     = (state_q == StHalted);
  assign bus.dtimeout = dto_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    dto_d   = dto_q;
    case (state_q)
      StHalted: ;
      default: begin
        if (bus.wbcuHALT) begin
          state_d = StHalted;
          wcnt_d  = '0;
        end else if (dstall) begin
          state_d = StDwait;
          if (wcnt_q != CntMax) wcnt_d = wcnt_q + 1'b1;
          if ((DWAIT_MAX != 0) && (wcnt_d == CntMax)) dto_d = 1'b1;
        end else begin
          state_d = StRun;
          wcnt_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StRun;
      wcnt_q  <= '0;
      dto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      dto_q   <= dto_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stallcnt_q, flushcnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stallcnt_q <= '0;
      flushcnt_q <= '0;
    end else if (state_q != StHalted) begin
      if (!pc_w) stallcnt_q <= stallcnt_q + 32'd1;
      if (flush_rule) flushcnt_q <= flushcnt_q + 32'd1;
    end
  end

  assign bus.stallcnt = stallcnt_q;
  assign bus.flushcnt = flushcnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a rule-level reference model checked every cycle.
// Build with HAZARD_PERF_EN to also check the stall/flush counters.
module tb_pipe_hazard_ctrl;

  localparam int unsigned DMAX = 4;

  // {pcW, ifidW,ifidRST, idexW,idexRST, exmemW,exmemRST, memW,memRST, halt, dtimeout}
  localparam logic [10:0] NORMAL    = 11'b1_10_10_10_10_0_0;
  localparam logic [10:0] NORMAL_TO = 11'b1_10_10_10_10_0_1;
  localparam logic [10:0] DSTALL    = 11'b0_00_00_00_01_0_0;
  localparam logic [10:0] DSTALL_TO = 11'b0_00_00_00_01_0_1;
  localparam logic [10:0] LOADUSE   = 11'b0_00_01_10_10_0_0;
  localparam logic [10:0] BRANCH    = 11'b1_01_01_10_10_0_0;
  localparam logic [10:0] IMISS     = 11'b0_01_10_10_10_0_0;
  localparam logic [10:0] HALTCYC   = 11'b0_00_00_00_01_0_0;
  localparam logic [10:0] HALTED    = 11'b0_00_00_00_00_1_0;

  logic CLK = 1'b0;
  logic nRST;
  int   ncmp = 0;
  int   nfail = 0;

  pipe_hazard_ctrl_if #(.REGW(5)) bus ();

  pipe_hazard_ctrl #(
    .DWAIT_MAX(DMAX),
    .REGW     (5)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [10:0] dut_vec;
  assign dut_vec = {bus.pcW, bus.ifidW, bus.ifidRST, bus.idexW, bus.idexRST, bus.exmemW,
                    bus.exmemRST, bus.memW, bus.memRST, bus.halt, bus.dtimeout};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // Reference model: outputs derived from the hazard rules as whole-pipeline intents.
  logic        m_halted, m_tout;
  int          m_wcnt;
  logic [31:0] m_stallcnt, m_flushcnt;
  logic [10:0] m_exp;

  function automatic logic [10:0] expect_out(
    input logic halted, input logic tout, input logic ihit, input logic dhit, input logic dreq,
    input logic exdren, input logic [4:0] ws, input logic [4:0] rs, input logic [4:0] rt,
    input logic rtused, input logic pcsrc, input logic whalt);
    logic lu, flush_if, hold_if, bubble_ex, pc_go;
    lu = exdren && (ws != 0) && ((ws == rs) || (rtused && (ws == rt)));
    if (halted) return {9'b0, 1'b1, tout};
    if (whalt || (dreq && !dhit)) return {8'b0, 1'b1, 1'b0, tout};
    flush_if  = pcsrc || (!ihit && !lu);
    hold_if   = lu && !pcsrc;
    bubble_ex = pcsrc || lu;
    pc_go     = pcsrc || (ihit && !lu);
    return {pc_go, !(hold_if || flush_if), flush_if, !bubble_ex, bubble_ex, 4'b1010, 1'b0, tout};
  endfunction

  logic m_dreq;
  assign m_dreq = bus.memdREN | bus.memdWEN;
  assign m_exp  = expect_out(m_halted, m_tout, bus.ihit, bus.dhit, m_dreq, bus.exdREN,
                             bus.exwsel, bus.idrs, bus.idrt, bus.idrtUsed, bus.exPCSrc,
                             bus.wbcuHALT);

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_halted   <= 1'b0;
      m_tout     <= 1'b0;
      m_wcnt     <= 0;
      m_stallcnt <= '0;
      m_flushcnt <= '0;
    end else if (!m_halted) begin
      if (!m_exp[10]) m_stallcnt <= m_stallcnt + 1;
      if (!bus.wbcuHALT && !(m_dreq && !bus.dhit) && bus.exPCSrc) m_flushcnt <= m_flushcnt + 1;
      if (bus.wbcuHALT) begin
        m_halted <= 1'b1;
        m_wcnt   <= 0;
      end else if (m_dreq && !bus.dhit) begin
        m_wcnt <= (m_wcnt + 1 > DMAX) ? DMAX : m_wcnt + 1;
        if (m_wcnt + 1 >= DMAX) m_tout <= 1'b1;
      end else begin
        m_wcnt <= 0;
      end
    end
  end

  always @(negedge CLK) begin
    chk("model_outputs", {21'b0, dut_vec}, {21'b0, m_exp});
`ifdef HAZARD_PERF_EN
    chk("stallcnt", bus.stallcnt, m_stallcnt);
    chk("flushcnt", bus.flushcnt, m_flushcnt);
`endif
  end

  task automatic idle();
    bus.ihit     = 1'b1;
    bus.dhit     = 1'b0;
    bus.memdREN  = 1'b0;
    bus.memdWEN  = 1'b0;
    bus.exdREN   = 1'b0;
    bus.exwsel   = 5'd0;
    bus.idrs     = 5'd0;
    bus.idrt     = 5'd0;
    bus.idrtUsed = 1'b0;
    bus.exPCSrc  = 1'b0;
    bus.wbcuHALT = 1'b0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic vec(input string nm, input logic [10:0] exp);
    #2;
    chk(nm, {21'b0, dut_vec}, {21'b0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    nRST = 1'b0;
    vec("reset_state", NORMAL);
    cyc(); nRST = 1'b1;
    vec("run_idle", NORMAL);

    for (int i = 0; i < 3; i++) begin
      cyc(); bus.memdREN = 1'b1; bus.dhit = 1'b0;
      vec("dmem_stall", DSTALL);
    end
    cyc(); bus.dhit = 1'b1;
    vec("dmem_done", NORMAL);
    cyc(); idle();

    bus.exdREN = 1'b1; bus.exwsel = 5'd8; bus.idrs = 5'd8;
    vec("load_use_rs", LOADUSE);
    cyc(); bus.exwsel = 5'd0;
    vec("load_use_r0", NORMAL);
    cyc(); bus.exwsel = 5'd8; bus.idrs = 5'd3; bus.idrt = 5'd8; bus.idrtUsed = 1'b1;
    vec("load_use_rt", LOADUSE);
    cyc(); bus.idrtUsed = 1'b0;
    vec("rt_unused", NORMAL);
    cyc(); bus.idrs = 5'd8; bus.ihit = 1'b0;
    vec("load_use_imiss", LOADUSE);
    cyc(); bus.exdREN = 1'b0;
    vec("imiss", IMISS);
    cyc(); bus.exdREN = 1'b1; bus.exPCSrc = 1'b1; bus.ihit = 1'b1;
    vec("branch_over_lu", BRANCH);
    cyc(); idle();

    for (int i = 0; i < 4; i++) begin
      cyc(); bus.memdREN = 1'b1; bus.dhit = 1'b0;
      vec("dwait_pre_to", DSTALL);
    end
    cyc();
    vec("dwait_timeout", DSTALL_TO);
    cyc(); bus.dhit = 1'b1;
    vec("to_sticky_dhit", NORMAL_TO);
    cyc(); idle();
    vec("to_sticky_idle", NORMAL_TO);

    cyc(); #1 nRST = 1'b0;
    #1 chk("async_rst_to", {21'b0, dut_vec}, {21'b0, NORMAL});
    cyc(); nRST = 1'b1;

    cyc(); bus.wbcuHALT = 1'b1;
    vec("halt_cycle", HALTCYC);
    cyc(); bus.wbcuHALT = 1'b0;
    vec("halted", HALTED);
    for (int i = 0; i < 6; i++) begin
      cyc(); bus.ihit = i[0]; bus.dhit = ~i[0]; bus.memdREN = i[1]; bus.exPCSrc = i[2];
      vec("halted_absorb", HALTED);
    end

    cyc(); idle(); #1 nRST = 1'b0;
    #1 chk("async_rst_halt", {21'b0, dut_vec}, {21'b0, NORMAL});
    cyc(); nRST = 1'b1;
    cyc();
    vec("run_after_rst", NORMAL);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
